// File: rtl/pipe_skid_2.sv
// Two-lane valid/ready pipeline stage with a one-entry skid buffer.
// Paired words travel together; a stall reaches the producer one cycle late through a registered s_ready.
module pipe_skid_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_d1,
  input  logic [WIDTH-1:0] s_d2,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_q1,
  output logic [WIDTH-1:0] m_q2,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  logic             m_valid_r;
  logic             s_ready_r;
  logic [1:0]       count_r;
  logic [WIDTH-1:0] main_q1_r;
  logic [WIDTH-1:0] main_q2_r;
  logic [WIDTH-1:0] skid_q1_r;
  logic [WIDTH-1:0] skid_q2_r;
  logic             accept_s;
  logic             deliver_s;

  // Handshake qualifiers, built only from registered flags so m_ready never reaches s_ready.
  always_comb begin
    accept_s  = 1'b0;
    deliver_s = 1'b0;
    if (s_valid && s_ready_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (m_valid_r && m_ready) begin
      deliver_s = 1'b1;
    end else begin
      deliver_s = 1'b0;
    end
  end

  // State machine with registered status flags and data registers.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state_r   <= EMPTY;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b1;
      count_r   <= 2'd0;
      main_q1_r <= {WIDTH{1'b0}};
      main_q2_r <= {WIDTH{1'b0}};
      skid_q1_r <= {WIDTH{1'b0}};
      skid_q2_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_q1_r <= s_d1;
            main_q2_r <= s_d2;
            state_r   <= BUSY;
            m_valid_r <= 1'b1;
            s_ready_r <= 1'b1;
            count_r   <= 2'd1;
          end
        end
        BUSY: begin
          if (accept_s && deliver_s) begin
            main_q1_r <= s_d1;
            main_q2_r <= s_d2;
          end else if (accept_s) begin
            // Consumer stalled: park the new beat behind the one on display.
            skid_q1_r <= s_d1;
            skid_q2_r <= s_d2;
            state_r   <= FULL;
            s_ready_r <= 1'b0;
            count_r   <= 2'd2;
          end else if (deliver_s) begin
            state_r   <= EMPTY;
            m_valid_r <= 1'b0;
            count_r   <= 2'd0;
          end
        end
        FULL: begin
          if (deliver_s) begin
            main_q1_r <= skid_q1_r;
            main_q2_r <= skid_q2_r;
            state_r   <= BUSY;
            s_ready_r <= 1'b1;
            count_r   <= 2'd1;
          end
        end
        default: begin
          state_r   <= EMPTY;
          m_valid_r <= 1'b0;
          s_ready_r <= 1'b1;
          count_r   <= 2'd0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign count   = count_r;
  assign m_q1    = main_q1_r;
  assign m_q2    = main_q2_r;

endmodule

// File: tb/tb_pipe_skid_2.sv
// Directed and scoreboarded checks for the two-lane skid stage at WIDTH=32.
module tb_pipe_skid_2;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_d1;
  logic [W-1:0] s_d2;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_q1;
  logic [W-1:0] m_q2;
  logic [1:0]   count;

  int compared   = 0;
  int mismatched = 0;

  pipe_skid_2 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_d1    (s_d1),
    .s_d2    (s_d2),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_q1    (m_q1),
    .m_q2    (m_q2),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic mv, input logic sr, input logic [1:0] c);
    chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, mv});
    chk({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, sr});
    chk({tag, ".count"},   {30'd0, count},   {30'd0, c});
  endtask

  task automatic chk_data(input string tag, input logic [W-1:0] e1, input logic [W-1:0] e2);
    chk({tag, ".m_q1"}, m_q1, e1);
    chk({tag, ".m_q2"}, m_q2, e2);
  endtask

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] front;
  logic           acc;
  logic           del;

  initial begin
    reset = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_d1 = 32'h0; s_d2 = 32'h0;
    step(); step();
    chk_status("reset", 1'b0, 1'b1, 2'd0);
    chk_data("reset", 32'h0, 32'h0);

    // 1: streaming, one beat per cycle
    reset = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
    s_d1 = 32'h10; s_d2 = 32'h20; step();
    chk_status("s1a", 1'b1, 1'b1, 2'd1); chk_data("s1a", 32'h10, 32'h20);
    s_d1 = 32'h11; s_d2 = 32'h21; step();
    chk_status("s1b", 1'b1, 1'b1, 2'd1); chk_data("s1b", 32'h11, 32'h21);
    s_d1 = 32'h12; s_d2 = 32'h22; step();
    chk_status("s1c", 1'b1, 1'b1, 2'd1); chk_data("s1c", 32'h12, 32'h22);
    s_valid = 1'b0; step();
    chk_status("s1drain", 1'b0, 1'b1, 2'd0);

    // 2/3: backpressure into skid, then stall while full
    m_ready = 1'b0; s_valid = 1'b1; s_d1 = 32'h10; s_d2 = 32'h20; step();
    chk_status("s2busy", 1'b1, 1'b1, 2'd1); chk_data("s2busy", 32'h10, 32'h20);
    s_d1 = 32'h11; s_d2 = 32'h21; step();
    chk_status("s2full", 1'b1, 1'b0, 2'd2); chk_data("s2full", 32'h10, 32'h20);
    for (int i = 0; i < 5; i++) begin
      s_d1 = 32'h30 + i; s_d2 = 32'h40 + i; step();
      chk_status("s3stall", 1'b1, 1'b0, 2'd2); chk_data("s3stall", 32'h10, 32'h20);
    end
    m_ready = 1'b1; s_valid = 1'b0; step();
    chk_status("s3rel", 1'b1, 1'b1, 2'd1); chk_data("s3rel", 32'h11, 32'h21);
    step();
    chk_status("s3empty", 1'b0, 1'b1, 2'd0);

    // 4: flush while full with both sides active
    m_ready = 1'b0; s_valid = 1'b1; s_d1 = 32'h40; s_d2 = 32'h50; step();
    s_d1 = 32'h41; s_d2 = 32'h51; step();
    chk_status("s4full", 1'b1, 1'b0, 2'd2);
    flush = 1'b1; m_ready = 1'b1; s_d1 = 32'h42; s_d2 = 32'h52; step();
    chk_status("s4flush", 1'b0, 1'b1, 2'd0); chk_data("s4flush", 32'h0, 32'h0);
    flush = 1'b0; s_valid = 1'b0; step();
    chk_status("s4after", 1'b0, 1'b1, 2'd0); chk_data("s4after", 32'h0, 32'h0);

    // 5: reset mid-stream together with flush
    m_ready = 1'b0; s_valid = 1'b1; s_d1 = 32'h60; s_d2 = 32'h70; step();
    chk_status("s5busy", 1'b1, 1'b1, 2'd1);
    reset = 1'b0; flush = 1'b1; step();
    chk_status("s5rst", 1'b0, 1'b1, 2'd0); chk_data("s5rst", 32'h0, 32'h0);
    reset = 1'b1; flush = 1'b0; s_d1 = 32'hAA; s_d2 = 32'hBB; step();
    chk_status("s5new", 1'b1, 1'b1, 2'd1); chk_data("s5new", 32'hAA, 32'hBB);
    s_valid = 1'b0; m_ready = 1'b1; step();
    chk_status("s5drain", 1'b0, 1'b1, 2'd0);

    // 6: random valid/ready against a FIFO model
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_d1 = $urandom; s_d2 = $urandom;
      chk_status("rnd", exp_q.size() > 0, exp_q.size() < 2, exp_q.size());
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        chk_data("rnd", front[2*W-1:W], front[W-1:0]);
      end
      acc = s_valid && (exp_q.size() < 2);
      del = m_ready && (exp_q.size() > 0);
      step();
      if (del) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({s_d1, s_d2});
    end
    chk_status("rndend", exp_q.size() > 0, exp_q.size() < 2, exp_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
